unet_pvm_top_sdiv_52s_18s_36_seq: RTL



---
 rtl/unet_pvm_div_pkg.sv | 31 +++
 rtl/unet_pvm_udiv_step.sv | 33 +++
 rtl/unet_pvm_top_sdiv_52s_18s_36_seq.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/unet_pvm_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : unet_pvm_div_pkg
// Description : Shared widths, saturation limits and FSM encoding for the
//               unet_pvm 52s / 18s -> 36s sequential signed divider.
// Revision    : 1.0 - initial release
// ============================================================================
package unet_pvm_div_pkg;

    localparam int DIVIDEND_WIDTH = 52;
    localparam int DIVISOR_WIDTH  = 18;
    localparam int QUOTIENT_WIDTH = 36;
    localparam int PREM_WIDTH     = DIVISOR_WIDTH + 1;
    localparam int CNT_WIDTH      = 6;
    localparam int LATENCY        = 54;

    localparam logic [QUOTIENT_WIDTH-1:0] QMAX = 36'h7_FFFF_FFFF;
    localparam logic [QUOTIENT_WIDTH-1:0] QMIN = 36'h8_0000_0000;

    localparam logic [CNT_WIDTH-1:0] ITER_LAST = 6'd51;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage : unet_pvm_div_pkg
`default_nettype wire

// File: rtl/unet_pvm_udiv_step.sv
`default_nettype none
// ============================================================================
// Module      : unet_pvm_udiv_step
// Description : One combinational radix-2 restoring division step on
//               unsigned magnitudes: shift in one dividend bit, trial
//               subtract the divisor, produce one quotient bit.
// Revision    : 1.0 - initial release
// ============================================================================
module unet_pvm_udiv_step
    import unet_pvm_div_pkg::*;
(
    input  logic [PREM_WIDTH-1:0]    i_prem,
    input  logic                     i_bit,
    input  logic [DIVISOR_WIDTH-1:0] i_dvsr,
    output logic [PREM_WIDTH-1:0]    o_prem,
    output logic                     o_qbit
);

    logic [PREM_WIDTH-1:0] w_shift;
    logic [PREM_WIDTH-1:0] w_diff;

    // The true shifted value is {i_prem, i_bit}; its top bit only ever
    // matters for "is it at least the divisor", so the arithmetic is done
    // modulo 2^19 and the dropped bit forces a successful subtraction.
    always_comb begin
        w_shift = {i_prem[PREM_WIDTH-2:0], i_bit};
        w_diff  = w_shift - {1'b0, i_dvsr};
        o_qbit  = i_prem[PREM_WIDTH-1] | (w_shift >= {1'b0, i_dvsr});
        o_prem  = o_qbit ? w_diff : w_shift;
    end

endmodule : unet_pvm_udiv_step
`default_nettype wire

// File: rtl/unet_pvm_top_sdiv_52s_18s_36_seq.sv
`default_nettype none
// ============================================================================
// Module      : unet_pvm_top_sdiv_52s_18s_36_seq
// Description : Fixed-latency (54 cycle) sequential signed divider,
//               52s / 18s -> 36s saturated quotient and 18s remainder,
//               valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module unet_pvm_top_sdiv_52s_18s_36_seq
    import unet_pvm_div_pkg::*;
(
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [QUOTIENT_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      div_zero,
    output logic                      overflow
);

    state_t                    r_state;
    logic [CNT_WIDTH-1:0]      r_cnt;
    logic [DIVIDEND_WIDTH-1:0] r_dvnd;
    logic [DIVISOR_WIDTH-1:0]  r_dvsr;
    logic [DIVIDEND_WIDTH-1:0] r_mag_n;
    logic [DIVISOR_WIDTH-1:0]  r_mag_d;
    logic [PREM_WIDTH-1:0]     r_prem;
    logic [DIVIDEND_WIDTH-1:0] r_quo;
    logic                      r_neg_res;
    logic                      r_neg_dvnd;
    logic                      r_dz;
    logic                      r_out_valid;
    logic [QUOTIENT_WIDTH-1:0] r_quotient;
    logic [DIVISOR_WIDTH-1:0]  r_remainder;
    logic                      r_div_zero;
    logic                      r_overflow;

    logic [PREM_WIDTH-1:0]     w_prem_nxt;
    logic                      w_qbit;
    logic                      w_ovf;
    logic [QUOTIENT_WIDTH-1:0] w_q_signed;
    logic [DIVISOR_WIDTH-1:0]  w_r_signed;

    unet_pvm_udiv_step u_step (
        .i_prem (r_prem),
        .i_bit  (r_mag_n[DIVIDEND_WIDTH-1]),
        .i_dvsr (r_mag_d),
        .o_prem (w_prem_nxt),
        .o_qbit (w_qbit)
    );

    // Ready only while idle and out of reset, so it drops the instant
    // reset is applied rather than one edge later.
    assign in_ready  = (r_state == IDLE) && !ap_rst;
    assign out_valid = r_out_valid;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign div_zero  = r_div_zero;
    assign overflow  = r_overflow;

    // Sign application and saturation detection on the finished magnitude;
    // a negative result may reach 2^35 exactly, a positive one only 2^35-1.
    always_comb begin
        w_ovf      = r_neg_res ? (r_quo > {16'd0, QMIN}) : (r_quo > {16'd0, QMAX});
        w_q_signed = r_neg_res ? (~r_quo[QUOTIENT_WIDTH-1:0] + 1'b1)
                               : r_quo[QUOTIENT_WIDTH-1:0];
        w_r_signed = r_neg_dvnd ? (~r_prem[DIVISOR_WIDTH-1:0] + 1'b1)
                                : r_prem[DIVISOR_WIDTH-1:0];
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_dvnd      <= '0;
            r_dvsr      <= '0;
            r_mag_n     <= '0;
            r_mag_d     <= '0;
            r_prem      <= '0;
            r_quo       <= '0;
            r_neg_res   <= 1'b0;
            r_neg_dvnd  <= 1'b0;
            r_dz        <= 1'b0;
            r_out_valid <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_dvnd  <= dividend;
                        r_dvsr  <= divisor;
                        r_state <= PREP;
                    end
                end
                PREP: begin
                    // Unsigned magnitudes hold 2^51 and 2^17 without loss.
                    r_mag_n    <= r_dvnd[DIVIDEND_WIDTH-1] ? (~r_dvnd + 1'b1) : r_dvnd;
                    r_mag_d    <= r_dvsr[DIVISOR_WIDTH-1]  ? (~r_dvsr + 1'b1) : r_dvsr;
                    r_neg_res  <= r_dvnd[DIVIDEND_WIDTH-1] ^ r_dvsr[DIVISOR_WIDTH-1];
                    r_neg_dvnd <= r_dvnd[DIVIDEND_WIDTH-1];
                    r_dz       <= (r_dvsr == '0);
                    r_prem     <= '0;
                    r_quo      <= '0;
                    r_cnt      <= ITER_LAST;
                    r_state    <= ITER;
                end
                ITER: begin
                    // Runs all 52 steps even for a zero divisor to keep latency fixed.
                    r_prem  <= w_prem_nxt;
                    r_mag_n <= {r_mag_n[DIVIDEND_WIDTH-2:0], 1'b0};
                    r_quo   <= {r_quo[DIVIDEND_WIDTH-2:0], w_qbit};
                    r_cnt   <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    if (r_dz) begin
                        r_quotient  <= r_neg_dvnd ? QMIN : QMAX;
                        r_remainder <= '0;
                        r_overflow  <= 1'b0;
                    end else begin
                        r_quotient  <= w_ovf ? (r_neg_res ? QMIN : QMAX) : w_q_signed;
                        r_remainder <= w_r_signed;
                        r_overflow  <= w_ovf;
                    end
                    r_div_zero  <= r_dz;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : unet_pvm_top_sdiv_52s_18s_36_seq
`default_nettype wire
